// File: rtl/seq_pkg.sv
// Shared types for the multi-cycle sequencer: FSM state encoding and
// memory address-select codes.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer around a single shared memory port,
// with a memory-wait timeout and saturating cycle/retired-instruction counters.
//
// state | meaning
// IDLE  | parked, waiting for run
// FETCH | instruction read at PC, wait for mem_ready
// EXEC  | decoded control bits valid, pick next step
// MEM   | load/store at ALU address, wait for mem_ready
// WB    | register write-back and PC commit
// HALT  | halt retired, sticky until rst
// ERROR | memory timeout, sticky until rst
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             memToReg,
    input  logic             memWrite,
    input  logic             regWrite,
    input  logic             halt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;

    logic w_live;
    logic w_mem_phase;
    logic w_timeout;
    logic w_store;
    logic w_retire;
    logic w_active;

    // memWrite takes precedence, so a load+store encoding behaves as a store
    assign w_store     = memWrite;
    assign w_mem_phase = (r_state == FETCH) || (r_state == MEM);
    assign w_timeout   = w_mem_phase && !mem_ready && (r_wait == WAIT_LAST);
    assign w_active    = (r_state == FETCH) || (r_state == EXEC) ||
                         (r_state == MEM)   || (r_state == WB);
    assign w_retire    = ((r_state == EXEC) && halt) ||
                         ((r_state == MEM) && mem_ready && w_store) ||
                         (r_state == WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state <= FETCH;
                        r_wait  <= '0;
                    end
                end
                FETCH: begin
                    if (mem_ready)      r_state <= EXEC;
                    else if (w_timeout) r_state <= ERROR;
                    else                r_wait  <= r_wait + WAIT_W'(1);
                end
                EXEC: begin
                    if (halt) begin
                        r_state <= HALT;
                    end else if (memToReg || memWrite) begin
                        r_state <= MEM;
                        r_wait  <= '0;
                    end else begin
                        r_state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (w_store) begin
                            r_state <= FETCH;
                            r_wait  <= '0;
                        end else begin
                            r_state <= WB;
                        end
                    end else if (w_timeout) begin
                        r_state <= ERROR;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                WB: begin
                    if (run) begin
                        r_state <= FETCH;
                        r_wait  <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HALT:    r_state <= HALT;
                ERROR:   r_state <= ERROR;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes are blanked while rst is high so an aborted instruction never commits
    assign w_live   = !rst;
    assign mem_req  = w_live && w_mem_phase;
    assign addr_sel = w_live && (r_state == MEM) ? ADDR_ALU : ADDR_PC;
    assign mem_we   = w_live && (r_state == MEM) && memWrite;
    assign ir_we    = w_live && (r_state == FETCH) && mem_ready;
    assign pc_we    = w_live && (((r_state == MEM) && mem_ready && w_store) ||
                                 (r_state == WB));
    assign rf_we    = w_live && (r_state == WB) && regWrite;
    assign halted   = w_live && (r_state == HALT);
    assign error    = w_live && (r_state == ERROR);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_active),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_retire),
        .q   (instr_cnt)
    );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer, built with MEM_TIMEOUT=4 and CNT_W=3
// so timeout and counter saturation are reachable in a few cycles.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       memToReg;
    logic       memWrite;
    logic       regWrite;
    logic       halt;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic       halted;
    logic       error;
    logic [2:0] cycle_cnt;
    logic [2:0] instr_cnt;

    int checks   = 0;
    int failures = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .memToReg  (memToReg),
        .memWrite  (memWrite),
        .regWrite  (regWrite),
        .halt      (halt),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .rf_we     (rf_we),
        .halted    (halted),
        .error     (error),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    `define CHK(tag, obs, exp) \
        begin \
            checks++; \
            assert ((obs) === (exp)) else begin \
                failures++; \
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); \
            end \
        end

    always @(negedge clk) begin
        if (halted === 1'b1 || error === 1'b1) begin
            checks++;
            if ((mem_req | mem_we | ir_we | pc_we | rf_we) !== 1'b0) begin
                failures++;
                $error("FAIL sticky_strobes observed=%0d expected=0",
                       mem_req | mem_we | ir_we | pc_we | rf_we);
            end
        end
        if ((halted & error) === 1'b1) begin
            failures++;
            $error("FAIL halted_and_error observed=1 expected=0");
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_dec(input logic m2r, input logic mw, input logic rw, input logic h);
        memToReg = m2r;
        memWrite = mw;
        regWrite = rw;
        halt     = h;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        #1;
        `CHK("rst_mem_req", mem_req, 1'b0)
        `CHK("rst_pc_we", pc_we, 1'b0)
        `CHK("rst_halted", halted, 1'b0)
        `CHK("rst_error", error, 1'b0)
        `CHK("rst_cycle_cnt", cycle_cnt, 3'd0)
        `CHK("rst_instr_cnt", instr_cnt, 3'd0)

        // R-type, memory always ready
        rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
        set_dec(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        `CHK("idle_ir_we", ir_we, 1'b0)
        `CHK("idle_mem_req", mem_req, 1'b0)
        tick(); #1;
        `CHK("r_fetch_req", mem_req, 1'b1)
        `CHK("r_fetch_addr", addr_sel, 1'b0)
        `CHK("r_fetch_ir_we", ir_we, 1'b1)
        `CHK("r_fetch_cycle", cycle_cnt, 3'd0)
        tick(); #1;
        `CHK("r_exec_req", mem_req, 1'b0)
        `CHK("r_exec_pc_we", pc_we, 1'b0)
        `CHK("r_exec_cycle", cycle_cnt, 3'd1)
        tick(); #1;
        `CHK("r_wb_rf_we", rf_we, 1'b1)
        `CHK("r_wb_pc_we", pc_we, 1'b1)
        `CHK("r_wb_instr", instr_cnt, 3'd0)

        // Load with three not-ready MEM cycles; ready on the last allowed cycle
        memToReg = 1'b1;
        tick(); #1;
        `CHK("ld_fetch_instr", instr_cnt, 3'd1)
        `CHK("ld_fetch_cycle", cycle_cnt, 3'd3)
        `CHK("ld_fetch_ir_we", ir_we, 1'b1)
        tick();
        mem_ready = 1'b0;
        tick(); #1;
        `CHK("ld_mem1_req", mem_req, 1'b1)
        `CHK("ld_mem1_addr", addr_sel, 1'b1)
        `CHK("ld_mem1_we", mem_we, 1'b0)
        `CHK("ld_mem1_pc_we", pc_we, 1'b0)
        tick(); tick(); #1;
        `CHK("ld_mem3_req", mem_req, 1'b1)
        `CHK("ld_mem3_error", error, 1'b0)
        tick();
        mem_ready = 1'b1; #1;
        `CHK("ld_mem4_pc_we", pc_we, 1'b0)
        `CHK("ld_mem4_rf_we", rf_we, 1'b0)
        `CHK("ld_mem4_req", mem_req, 1'b1)
        tick();
        run = 1'b0; #1;
        `CHK("ld_wb_rf_we", rf_we, 1'b1)
        `CHK("ld_wb_pc_we", pc_we, 1'b1)
        `CHK("ld_wb_error", error, 1'b0)
        tick(); #1;
        `CHK("ld_idle_req", mem_req, 1'b0)
        `CHK("ld_instr", instr_cnt, 3'd2)
        `CHK("cycle_saturated", cycle_cnt, 3'd7)

        // Store encoded with both memToReg and memWrite set
        run = 1'b1; mem_ready = 1'b1;
        set_dec(1'b1, 1'b1, 1'b0, 1'b0);
        tick(); tick(); #1;
        `CHK("st_exec_rf_we", rf_we, 1'b0)
        tick();
        run = 1'b0; #1;
        `CHK("st_mem_we", mem_we, 1'b1)
        `CHK("st_mem_pc_we", pc_we, 1'b1)
        `CHK("st_mem_rf_we", rf_we, 1'b0)
        `CHK("st_mem_addr", addr_sel, 1'b1)
        tick(); #1;
        `CHK("st_next_fetch_req", mem_req, 1'b1)
        `CHK("st_next_fetch_addr", addr_sel, 1'b0)
        `CHK("st_instr", instr_cnt, 3'd3)

        // Halt fetched while run is low; fetch already in progress
        set_dec(1'b0, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        `CHK("h_exec_pc_we", pc_we, 1'b0)
        `CHK("h_exec_halted", halted, 1'b0)
        tick(); #1;
        `CHK("h_halted", halted, 1'b1)
        `CHK("h_req", mem_req, 1'b0)
        `CHK("h_instr", instr_cnt, 3'd4)
        run = 1'b1; halt = 1'b0;
        tick(); #1;
        `CHK("h_stay_halted", halted, 1'b1)
        `CHK("h_stay_ir_we", ir_we, 1'b0)
        `CHK("h_stay_pc_we", pc_we, 1'b0)
        `CHK("h_stay_instr", instr_cnt, 3'd4)
        run = 1'b0; mem_ready = 1'b0;
        tick(); #1;
        `CHK("h_stay2_halted", halted, 1'b1)

        // Fetch timeout with mem_ready held low
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b1; mem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        `CHK("to_rst_halted", halted, 1'b0)
        `CHK("to_rst_instr", instr_cnt, 3'd0)
        tick(); tick(); tick(); tick(); #1;
        `CHK("to_fetch4_error", error, 1'b0)
        `CHK("to_fetch4_req", mem_req, 1'b1)
        tick(); #1;
        `CHK("to_error", error, 1'b1)
        `CHK("to_error_req", mem_req, 1'b0)
        mem_ready = 1'b1;
        tick(); #1;
        `CHK("to_error_sticky", error, 1'b1)
        `CHK("to_error_ir_we", ir_we, 1'b0)

        // mem_ready on the last allowed fetch cycle wins; then rst during WB
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b1; mem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        mem_ready = 1'b1; #1;
        `CHK("rdy4_ir_we", ir_we, 1'b1)
        tick(); #1;
        `CHK("rdy4_no_error", error, 1'b0)
        tick();
        rst = 1'b1; #1;
        `CHK("rst_wb_pc_we", pc_we, 1'b0)
        `CHK("rst_wb_rf_we", rf_we, 1'b0)
        tick();
        rst = 1'b0; run = 1'b0; #1;
        `CHK("rst_wb_idle_req", mem_req, 1'b0)
        `CHK("rst_wb_instr", instr_cnt, 3'd0)

        // rst during a store's MEM cycle that would otherwise commit
        run = 1'b1; mem_ready = 1'b1;
        set_dec(1'b0, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        run = 1'b0; rst = 1'b1; #1;
        `CHK("rst_mem_pc_we", pc_we, 1'b0)
        `CHK("rst_mem_rf_we", rf_we, 1'b0)
        tick();
        rst = 1'b0; #1;
        `CHK("rst_mem_idle_req", mem_req, 1'b0)
        `CHK("rst_mem_cycle", cycle_cnt, 3'd0)
        `CHK("rst_mem_instr", instr_cnt, 3'd0)

        // Eight-plus back-to-back R-types: instr_cnt must stick at 7
        run = 1'b1; mem_ready = 1'b1;
        set_dec(1'b0, 1'b0, 1'b1, 1'b0);
        tick(); #1;
        `CHK("sat_start_instr", instr_cnt, 3'd0)
        repeat (21) tick();
        #1;
        `CHK("sat_seven_instr", instr_cnt, 3'd7)
        repeat (9) tick();
        #1;
        `CHK("sat_hold_instr", instr_cnt, 3'd7)
        `CHK("sat_hold_cycle", cycle_cnt, 3'd7)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
